// File: rtl/ex_pipe_skid.sv
// EX->MEM pipeline register with a two-entry skid buffer, valid/ready on both sides,
// prioritised exception insertion and a saturating count of inserted exceptions.
module ex_pipe_skid #(
    parameter int                    PC_W      = 30,
    parameter int                    DATA_W    = 32,
    parameter int                    NEXP      = 2,
    parameter int                    EXP_W     = 3,
    parameter logic [NEXP*EXP_W-1:0] EXP_CODES = {3'h3, 3'h1},
    parameter int                    CNT_W     = 16
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [PC_W-1:0]   id_pc,
    input  logic              id_en,
    input  logic              id_br_flag,
    input  logic [1:0]        id_mem_op,
    input  logic [1:0]        id_ctrl_op,
    input  logic [DATA_W-1:0] id_mem_wdata,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [4:0]        id_dst_addr,
    input  logic              id_gpr_wen,
    input  logic [EXP_W-1:0]  id_exp_code,
    input  logic [NEXP-1:0]   exp_req,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [PC_W-1:0]   ex_pc,
    output logic              ex_en,
    output logic              ex_br_flag,
    output logic [1:0]        ex_mem_op,
    output logic [DATA_W-1:0] ex_mem_wdata,
    output logic [1:0]        ex_ctrl_op,
    output logic [4:0]        ex_dst_addr,
    output logic              ex_gpr_wen,
    output logic [EXP_W-1:0]  ex_exp_code,
    output logic [DATA_W-1:0] ex_out,
    output logic [CNT_W-1:0]  exp_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              en;
        logic              br_flag;
        logic [1:0]        mem_op;
        logic [DATA_W-1:0] mem_wdata;
        logic [1:0]        ctrl_op;
        logic [4:0]        dst_addr;
        logic              gpr_wen;
        logic [EXP_W-1:0]  exp_code;
        logic [DATA_W-1:0] out;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state_q;
    entry_t            head_q, skid_q;
    entry_t            rst_entry, cap;
    logic              valid_q, ready_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, drain, insert;
    logic [EXP_W-1:0]  exp_sel;

    assign accept = id_valid & ready_q;
    assign drain  = valid_q & ex_ready;
    assign insert = accept & id_en & (|exp_req);

    always_comb begin
        rst_entry         = '0;
        rst_entry.gpr_wen = 1'b1;
    end

    // Scan from the top so the lowest set request index wins.
    always_comb begin
        exp_sel = '0;
        for (int i = NEXP - 1; i >= 0; i--)
            if (exp_req[i]) exp_sel = EXP_CODES[i*EXP_W +: EXP_W];
    end

    always_comb begin
        cap.pc        = id_pc;
        cap.en        = id_en;
        cap.br_flag   = id_br_flag;
        cap.mem_op    = id_mem_op;
        cap.mem_wdata = id_mem_wdata;
        cap.ctrl_op   = id_ctrl_op;
        cap.dst_addr  = id_dst_addr;
        cap.gpr_wen   = id_gpr_wen;
        cap.exp_code  = id_exp_code;
        cap.out       = alu_out;
        if (id_en && (|exp_req)) begin
            cap.mem_op    = '0;
            cap.mem_wdata = '0;
            cap.ctrl_op   = '0;
            cap.dst_addr  = '0;
            cap.gpr_wen   = 1'b1;
            cap.exp_code  = exp_sel;
            cap.out       = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (insert && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    // id_ready is a register: it never depends combinationally on ex_ready.
    always_ff @(posedge cpu_clk or posedge cpu_rstn) begin
        if (cpu_rstn) begin
            state_q <= EMPTY;
            head_q  <= rst_entry;
            skid_q  <= rst_entry;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
            head_q  <= rst_entry;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            unique case (state_q)
                EMPTY: if (accept) begin
                    head_q  <= cap;
                    valid_q <= 1'b1;
                    state_q <= ONE;
                end
                ONE: if (accept && !drain) begin
                    skid_q  <= cap;
                    ready_q <= 1'b0;
                    state_q <= FULL;
                end else if (accept) begin
                    head_q  <= cap;
                end else if (drain) begin
                    valid_q <= 1'b0;
                    state_q <= EMPTY;
                end
                FULL: if (drain) begin
                    head_q  <= skid_q;
                    ready_q <= 1'b1;
                    state_q <= ONE;
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign id_ready     = ready_q;
    assign ex_valid     = valid_q;
    assign ex_pc        = head_q.pc;
    assign ex_en        = head_q.en;
    assign ex_br_flag   = head_q.br_flag;
    assign ex_mem_op    = head_q.mem_op;
    assign ex_mem_wdata = head_q.mem_wdata;
    assign ex_ctrl_op   = head_q.ctrl_op;
    assign ex_dst_addr  = head_q.dst_addr;
    assign ex_gpr_wen   = head_q.gpr_wen;
    assign ex_exp_code  = head_q.exp_code;
    assign ex_out       = head_q.out;
    assign exp_cnt      = cnt_q;

endmodule

// File: tb/tb_ex_pipe_skid.sv
// Bench for ex_pipe_skid: queue-based reference model, capture-rule table, hand corner
// sequences and randomized traffic. Counter is 2 bits wide to reach saturation quickly.
module tb_ex_pipe_skid;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br_flag;
        logic [1:0]  mem_op;
        logic [31:0] mem_wdata;
        logic [1:0]  ctrl_op;
        logic [4:0]  dst_addr;
        logic        gpr_wen;
        logic [2:0]  exp_code;
        logic [31:0] out;
    } ent_t;

    typedef struct {
        logic        en;
        logic [1:0]  req;
        logic [2:0]  icode;
        logic [31:0] alu;
        logic [2:0]  xcode;
        logic [31:0] xout;
        logic        xwen;
        logic [4:0]  xdst;
        int          xcnt;
    } vec_t;

    logic        cpu_clk = 1'b0, cpu_rstn = 1'b1, flush = 1'b0;
    logic        id_valid = 1'b0, ex_ready = 1'b0;
    logic [29:0] id_pc = '0;
    logic        id_en = 1'b0, id_br_flag = 1'b0, id_gpr_wen = 1'b0;
    logic [1:0]  id_mem_op = '0, id_ctrl_op = '0, exp_req = '0;
    logic [31:0] id_mem_wdata = '0, alu_out = '0;
    logic [4:0]  id_dst_addr = '0;
    logic [2:0]  id_exp_code = '0;
    logic        id_ready, ex_valid;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag, ex_gpr_wen;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wdata, ex_out;
    logic [4:0]  ex_dst_addr;
    logic [2:0]  ex_exp_code;
    logic [CNT_W-1:0] exp_cnt;

    ex_pipe_skid #(.PC_W(30), .DATA_W(32), .NEXP(2), .EXP_W(3),
                   .EXP_CODES({3'h3, 3'h1}), .CNT_W(CNT_W)) dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_en(id_en), .id_br_flag(id_br_flag),
        .id_mem_op(id_mem_op), .id_ctrl_op(id_ctrl_op),
        .id_mem_wdata(id_mem_wdata), .alu_out(alu_out),
        .id_dst_addr(id_dst_addr), .id_gpr_wen(id_gpr_wen),
        .id_exp_code(id_exp_code), .exp_req(exp_req),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag),
        .ex_mem_op(ex_mem_op), .ex_mem_wdata(ex_mem_wdata),
        .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_wen(ex_gpr_wen), .ex_exp_code(ex_exp_code),
        .ex_out(ex_out), .exp_cnt(exp_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    int   total = 0, bad = 0;
    ent_t m_q[$];
    ent_t m_last, rst_e;
    int   m_cnt;
    bit   m_ready;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic ent_t dut_ent();
        return {ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wdata, ex_ctrl_op,
                ex_dst_addr, ex_gpr_wen, ex_exp_code, ex_out};
    endfunction

    // Capture rule straight from the behavioural description (code 1 = interrupt, 3 = overflow).
    function automatic ent_t model_cap();
        ent_t e;
        e = '{pc: id_pc, en: id_en, br_flag: id_br_flag, mem_op: id_mem_op,
              mem_wdata: id_mem_wdata, ctrl_op: id_ctrl_op, dst_addr: id_dst_addr,
              gpr_wen: id_gpr_wen, exp_code: id_exp_code, out: alu_out};
        if (id_en && exp_req != 2'b00) begin
            e.mem_op = 0; e.mem_wdata = 0; e.ctrl_op = 0; e.dst_addr = 0;
            e.out = 0; e.gpr_wen = 1'b1;
            e.exp_code = exp_req[0] ? 3'h1 : 3'h3;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_last  = rst_e;
        m_cnt   = 0;
        m_ready = 1'b1;
    endtask

    task automatic check_model(input string tag);
        ent_t shown;
        shown = (m_q.size() > 0) ? m_q[0] : m_last;
        chk({tag, ".ex_valid"}, ex_valid, m_q.size() > 0);
        chk({tag, ".id_ready"}, id_ready, m_ready);
        chk({tag, ".exp_cnt"}, exp_cnt, m_cnt);
        chk({tag, ".entry"}, dut_ent(), shown);
    endtask

    // One clock: advance the model with the current inputs, then sample on the falling edge.
    task automatic step(input string tag);
        bit acc, drn;
        if (flush) begin
            m_q.delete();
            m_last = rst_e;
        end else begin
            acc = id_valid && m_ready;
            drn = (m_q.size() > 0) && ex_ready;
            if (drn) m_last = m_q.pop_front();
            if (acc) begin
                m_q.push_back(model_cap());
                if (id_en && exp_req != 2'b00 && m_cnt < 3) m_cnt++;
            end
        end
        m_ready = m_q.size() < 2;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        check_model(tag);
    endtask

    task automatic do_reset();
        cpu_rstn = 1'b1;
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0; exp_req = '0;
        repeat (2) @(negedge cpu_clk);
        cpu_rstn = 1'b0;
        model_reset();
    endtask

    task automatic set_plain(input logic [29:0] pc);
        id_pc = pc; id_en = 1'b1; id_br_flag = pc[0]; id_mem_op = 2'b01;
        id_ctrl_op = 2'b10; id_mem_wdata = {2'b0, pc}; alu_out = 32'hA000_0000 | pc;
        id_dst_addr = pc[4:0]; id_gpr_wen = 1'b0; id_exp_code = 3'h0; exp_req = 2'b00;
    endtask

    task automatic rand_inputs();
        id_valid     = ($urandom_range(3) != 0);
        ex_ready     = ($urandom_range(2) != 0);
        flush        = ($urandom_range(31) == 0);
        id_pc        = 30'($urandom);
        id_en        = ($urandom_range(3) != 0);
        id_br_flag   = 1'($urandom);
        id_mem_op    = 2'($urandom);
        id_ctrl_op   = 2'($urandom);
        id_mem_wdata = $urandom;
        alu_out      = $urandom;
        id_dst_addr  = 5'($urandom);
        id_gpr_wen   = 1'($urandom);
        id_exp_code  = 3'($urandom);
        exp_req      = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
    endtask

    vec_t tbl[6];

    initial begin
        rst_e = '0;
        rst_e.gpr_wen = 1'b1;
        tbl[0] = '{1'b1, 2'b11, 3'h0, 32'hDEAD, 3'h1, 32'h0,    1'b1, 5'h00, 1};
        tbl[1] = '{1'b1, 2'b10, 3'h0, 32'hBEEF, 3'h3, 32'h0,    1'b1, 5'h00, 2};
        tbl[2] = '{1'b0, 2'b01, 3'h5, 32'h1111, 3'h5, 32'h1111, 1'b0, 5'h0A, 2};
        tbl[3] = '{1'b1, 2'b00, 3'h2, 32'h2222, 3'h2, 32'h2222, 1'b0, 5'h0A, 2};
        tbl[4] = '{1'b1, 2'b01, 3'h0, 32'h3333, 3'h1, 32'h0,    1'b1, 5'h00, 3};
        tbl[5] = '{1'b1, 2'b10, 3'h0, 32'h4444, 3'h3, 32'h0,    1'b1, 5'h00, 3};

        // Reset state
        do_reset();
        check_model("reset");

        // Back-to-back stream, head replaced each cycle
        ex_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_plain(30'd100 + 30'(i));
            id_valid = 1'b1;
            step("stream");
            chk("stream.pc", ex_pc, 100 + i);
        end
        id_valid = 1'b0;
        step("stream.tail");
        step("stream.idle");

        // Backpressure: 3 offered, 2 captured, ordered drain
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_plain(30'd200 + 30'(i));
            id_valid = 1'b1;
            step("bp.fill");
        end
        chk("bp.ready_low", id_ready, 1'b0);
        id_valid = 1'b0;
        step("bp.hold");
        ex_ready = 1'b1;
        step("bp.drain1");
        chk("bp.pc_second", ex_pc, 201);
        chk("bp.ready_back", id_ready, 1'b1);
        step("bp.drain2");
        chk("bp.empty", ex_valid, 1'b0);

        // Capture-rule table
        do_reset();
        ex_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_plain(30'd300 + 30'(i));
            id_en = tbl[i].en; exp_req = tbl[i].req; id_exp_code = tbl[i].icode;
            alu_out = tbl[i].alu; id_dst_addr = 5'h0A;
            id_valid = 1'b1;
            step("tbl");
            chk("tbl.code", ex_exp_code, tbl[i].xcode);
            chk("tbl.out", ex_out, tbl[i].xout);
            chk("tbl.wen", ex_gpr_wen, tbl[i].xwen);
            chk("tbl.dst", ex_dst_addr, tbl[i].xdst);
            chk("tbl.cnt", exp_cnt, tbl[i].xcnt);
        end
        id_valid = 1'b0;
        step("tbl.drain");

        // Flush while FULL with a same-cycle offer
        ex_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_plain(30'd400 + 30'(i));
            exp_req = 2'b01;
            id_valid = 1'b1;
            step("fl.fill");
        end
        set_plain(30'd500);
        flush = 1'b1;
        step("fl.flush");
        chk("fl.valid", ex_valid, 1'b0);
        chk("fl.ready", id_ready, 1'b1);
        chk("fl.wen", ex_gpr_wen, 1'b1);
        flush = 1'b0; id_valid = 1'b0;
        step("fl.lost");

        // Async reset while FULL
        for (int i = 0; i < 2; i++) begin
            set_plain(30'd600 + 30'(i));
            exp_req = 2'b10;
            id_valid = 1'b1;
            step("ar.fill");
        end
        id_valid = 1'b0;
        #2 cpu_rstn = 1'b1;
        #1;
        model_reset();
        chk("ar.valid", ex_valid, 1'b0);
        chk("ar.ready", id_ready, 1'b1);
        chk("ar.cnt", exp_cnt, 0);
        chk("ar.entry", dut_ent(), rst_e);
        @(negedge cpu_clk);
        cpu_rstn = 1'b0;

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            rand_inputs();
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
